// File: rtl/rng_pkg.sv
// Shared definitions for the TRNG post-processing slice.
// Contents: controller state enum, default parameter values, and a helper
// that sizes a counter able to hold a given maximum value.
package rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAIL   = 2'd3
  } state_e;

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_WARMUP_CYC = 1024;
  localparam int DEF_REP_CUTOFF = 32;
  localparam int DEF_APT_WIN    = 512;
  localparam int DEF_APT_CUTOFF = 410;

  // Bits needed for a counter that must represent 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rng_health.sv
// Continuous health tests on the synchronized raw bit stream.
// Ports:
//   clk, rst_n     clock and async active-low reset
//   raw_q          synchronized raw bit under test
//   active         evaluate raw_q this cycle
//   clear          restart both tests (next bit begins a new run and window)
//   rep_trip       run of identical bits reaches REP_CUTOFF this cycle
//   apt_trip       window reference count reaches APT_CUTOFF this cycle
module rng_health
  import rng_pkg::*;
#(
  parameter int REP_CUTOFF = DEF_REP_CUTOFF,
  parameter int APT_WIN    = DEF_APT_WIN,
  parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_q,
  input  logic active,
  input  logic clear,
  output logic rep_trip,
  output logic apt_trip
);

  localparam int RW = cnt_w(REP_CUTOFF);
  localparam int AW = cnt_w(APT_CUTOFF);
  localparam int PW = cnt_w(APT_WIN);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          prev_q, prev_d;
  logic [AW-1:0] apt_cnt_q, apt_cnt_d;
  logic          apt_ref_q, apt_ref_d;
  logic [PW-1:0] apt_pos_q, apt_pos_d;

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    prev_d    = prev_q;
    apt_cnt_d = apt_cnt_q;
    apt_ref_d = apt_ref_q;
    apt_pos_d = apt_pos_q;
    rep_trip  = 1'b0;
    apt_trip  = 1'b0;
    if (clear) begin
      rep_cnt_d = '0;
      apt_cnt_d = '0;
      apt_pos_d = '0;
    end else if (active) begin
      prev_d = raw_q;
      // A zero run count means no bit has been seen since the last clear.
      if (rep_cnt_q == '0 || raw_q != prev_q) begin
        rep_cnt_d = RW'(1);
      end else if (rep_cnt_q != RW'(REP_CUTOFF)) begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
      rep_trip = (rep_cnt_d == RW'(REP_CUTOFF));

      if (apt_pos_q == '0) begin
        apt_ref_d = raw_q;
        apt_cnt_d = AW'(1);
      end else if (raw_q == apt_ref_q && apt_cnt_q != AW'(APT_CUTOFF)) begin
        apt_cnt_d = apt_cnt_q + AW'(1);
      end
      apt_trip  = (apt_cnt_d == AW'(APT_CUTOFF));
      apt_pos_d = (apt_pos_q == PW'(APT_WIN - 1)) ? '0 : apt_pos_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
      prev_q    <= 1'b0;
      apt_cnt_q <= '0;
      apt_ref_q <= 1'b0;
      apt_pos_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      prev_q    <= prev_d;
      apt_cnt_q <= apt_cnt_d;
      apt_ref_q <= apt_ref_d;
      apt_pos_q <= apt_pos_d;
    end
  end

endmodule

// File: rtl/rng_postproc.sv
// TRNG post-processor: health tests, von Neumann extraction, word packing
// and a valid/ready output register. Also gates the oscillator enable.
// Ports:
//   clk, rst_n     clock and async active-low reset
//   en             run request; low returns to idle
//   raw_bit        sampled generator output (resynchronized into raw_q)
//   osc_enable     generator enable
//   word_out       packed word, first extracted bit in the MSB
//   word_valid     word_out holds an unconsumed word
//   word_ready     consumer accepts word_out
//   health_fail    sticky failure, fail_rep / fail_apt give the cause
//
// state      | meaning
// ST_IDLE    | oscillators off, waiting for en
// ST_WARMUP  | oscillators on, bits discarded, health tests running
// ST_RUN     | extraction and packing active
// ST_FAIL    | health test tripped, oscillators off until en drops
module rng_postproc
  import rng_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int WARMUP_CYC = DEF_WARMUP_CYC,
  parameter int REP_CUTOFF = DEF_REP_CUTOFF,
  parameter int APT_WIN    = DEF_APT_WIN,
  parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              raw_bit,
  output logic              osc_enable,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              health_fail,
  output logic              fail_rep,
  output logic              fail_apt
);

  localparam int WU_W = cnt_w(WARMUP_CYC);
  localparam int PK_W = cnt_w(WORD_W);

  state_e            state_q, state_d;
  logic              raw_q;
  logic [WU_W-1:0]   wu_cnt_q, wu_cnt_d;
  logic              phase_q, phase_d;
  logic              first_q, first_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [PK_W-1:0]   pack_cnt_q, pack_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              osc_q, osc_d;
  logic              hf_q, hf_d;
  logic              frep_q, frep_d;
  logic              fapt_q, fapt_d;
  logic              rep_trip, apt_trip;
  logic              pack_full, xfer;

  rng_health #(
    .REP_CUTOFF (REP_CUTOFF),
    .APT_WIN    (APT_WIN),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_health (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_q    (raw_q),
    .active   (en && (state_q == ST_WARMUP || state_q == ST_RUN)),
    .clear    (state_q == ST_IDLE),
    .rep_trip (rep_trip),
    .apt_trip (apt_trip)
  );

  always_comb begin
    state_d    = state_q;
    wu_cnt_d   = wu_cnt_q;
    phase_d    = 1'b0;
    first_d    = first_q;
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt_q;
    word_d     = word_q;
    valid_d    = valid_q;
    hf_d       = hf_q;
    frep_d     = frep_q;
    fapt_d     = fapt_q;
    pack_full  = (pack_cnt_q == PK_W'(WORD_W));
    xfer       = valid_q & word_ready;
    if (xfer) valid_d = 1'b0;

    if (!en) begin
      state_d    = ST_IDLE;
      valid_d    = 1'b0;
      pack_cnt_d = '0;
      hf_d       = 1'b0;
      frep_d     = 1'b0;
      fapt_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_WARMUP;
          wu_cnt_d   = WU_W'(WARMUP_CYC - 1);
          pack_cnt_d = '0;
        end
        ST_WARMUP, ST_RUN: begin
          if (rep_trip || apt_trip) begin
            state_d    = ST_FAIL;
            valid_d    = 1'b0;
            pack_cnt_d = '0;
            hf_d       = 1'b1;
            frep_d     = frep_q | rep_trip;
            fapt_d     = fapt_q | apt_trip;
          end else if (state_q == ST_WARMUP) begin
            if (wu_cnt_q == '0) state_d = ST_RUN;
            else                wu_cnt_d = wu_cnt_q - WU_W'(1);
          end else begin
            phase_d = ~phase_q;
            if (!phase_q) begin
              first_d = raw_q;
            end else if (first_q != raw_q && !pack_full) begin
              // 10 yields 1, 01 yields 0: the yielded bit is the pair's first bit.
              pack_d     = {pack_q[WORD_W-2:0], first_q};
              pack_cnt_d = pack_cnt_q + PK_W'(1);
            end
            // A full pack drops new bits until the output register frees up.
            if (pack_full && (!valid_q || xfer)) begin
              word_d     = pack_q;
              valid_d    = 1'b1;
              pack_cnt_d = '0;
            end
          end
        end
        ST_FAIL: valid_d = 1'b0;
        default: state_d = ST_IDLE;
      endcase
    end
    osc_d = (state_d == ST_WARMUP) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      raw_q      <= 1'b0;
      wu_cnt_q   <= '0;
      phase_q    <= 1'b0;
      first_q    <= 1'b0;
      pack_q     <= '0;
      pack_cnt_q <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      osc_q      <= 1'b0;
      hf_q       <= 1'b0;
      frep_q     <= 1'b0;
      fapt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      raw_q      <= raw_bit;
      wu_cnt_q   <= wu_cnt_d;
      phase_q    <= phase_d;
      first_q    <= first_d;
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      osc_q      <= osc_d;
      hf_q       <= hf_d;
      frep_q     <= frep_d;
      fapt_q     <= fapt_d;
    end
  end

  assign osc_enable  = osc_q;
  assign word_out    = word_q;
  assign word_valid  = valid_q;
  assign health_fail = hf_q;
  assign fail_rep    = frep_q;
  assign fail_apt    = fapt_q;

endmodule

// File: tb/tb_rng_postproc.sv
module tb_rng_postproc;

  localparam int WW  = 8;
  localparam int WU  = 4;
  localparam int REP = 8;
  localparam int AWN = 16;
  localparam int ACT = 13;

  localparam int M_IDLE = 0;
  localparam int M_WARM = 1;
  localparam int M_RUN  = 2;
  localparam int M_FAIL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          raw_bit = 1'b0;
  logic          word_ready = 1'b0;
  logic          osc_enable, word_valid, health_fail, fail_rep, fail_apt;
  logic [WW-1:0] word_out;

  int total = 0;
  int bad   = 0;
  int n_xfer = 0;
  logic [WW-1:0] last_word = '0;

  rng_postproc #(
    .WORD_W(WW), .WARMUP_CYC(WU), .REP_CUTOFF(REP), .APT_WIN(AWN), .APT_CUTOFF(ACT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .raw_bit(raw_bit),
    .osc_enable(osc_enable), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .health_fail(health_fail),
    .fail_rep(fail_rep), .fail_apt(fail_apt)
  );

  always #5 clk = ~clk;

  // Reference model: session history of tested bits, pair extraction by
  // index parity, packing as a bit list, output register as occupancy flag.
  int            m_mode = M_IDLE;
  bit            m_raw, m_osc, m_valid, m_rep, m_apt;
  bit            sess[$];
  bit            pack[$];
  logic [WW-1:0] exp_q[$];

  task automatic model_reset();
    m_mode = M_IDLE; m_raw = 0; m_osc = 0; m_valid = 0; m_rep = 0; m_apt = 0;
    sess.delete(); pack.delete(); exp_q.delete();
  endtask

  task automatic model_step();
    bit b, xfer, full;
    int n, run, ws, cnt;
    logic [WW-1:0] w;
    b = m_raw;
    xfer = m_valid && word_ready;
    if (!en) begin
      if (m_valid && !xfer) void'(exp_q.pop_back());
      m_valid = 0; m_mode = M_IDLE; m_rep = 0; m_apt = 0; pack.delete();
    end else if (m_mode == M_IDLE) begin
      m_mode = M_WARM; sess.delete(); pack.delete();
    end else if (m_mode == M_WARM || m_mode == M_RUN) begin
      sess.push_back(b);
      n = sess.size();
      run = 0;
      for (int i = n - 1; i >= 0; i--) begin
        if (sess[i] != b) break;
        run++;
      end
      ws = ((n - 1) / AWN) * AWN;
      cnt = 0;
      for (int i = ws; i < n; i++) if (sess[i] == sess[ws]) cnt++;
      if (run >= REP || cnt >= ACT) begin
        m_rep = (run >= REP); m_apt = (cnt >= ACT);
        if (m_valid && !xfer) void'(exp_q.pop_back());
        m_valid = 0; m_mode = M_FAIL; pack.delete();
      end else if (m_mode == M_WARM) begin
        if (n == WU) m_mode = M_RUN;
      end else begin
        full = (pack.size() == WW);
        if (((n - 1 - WU) % 2) == 1 && sess[n-2] != b && !full) pack.push_back(sess[n-2]);
        if (xfer) m_valid = 0;
        if (full && !m_valid) begin
          w = '0;
          for (int i = 0; i < WW; i++) w[WW-1-i] = pack[i];
          exp_q.push_back(w);
          m_valid = 1;
          pack.delete();
        end
      end
    end
    m_osc = (m_mode == M_WARM || m_mode == M_RUN);
    m_raw = raw_bit;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Monitor: control outputs every cycle, words against the scoreboard.
  always @(negedge clk) begin
    total++;
    if ({osc_enable, health_fail, fail_rep, fail_apt, word_valid} !==
        {m_osc, m_rep | m_apt, m_rep, m_apt, m_valid}) begin
      bad++;
      $display("FAIL ctrl @%0t: got osc/hf/rep/apt/valid=%b%b%b%b%b want %b%b%b%b%b", $time,
               osc_enable, health_fail, fail_rep, fail_apt, word_valid,
               m_osc, m_rep | m_apt, m_rep, m_apt, m_valid);
    end
    if (word_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL word @%0t: got valid word %0h want no word", $time, word_out);
      end else begin
        if (word_out !== exp_q[0]) begin
          bad++;
          $display("FAIL word @%0t: got %0h want %0h", $time, word_out, exp_q[0]);
        end
        if (word_ready) begin
          last_word = word_out;
          n_xfer++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit b, input bit r);
    raw_bit = b; word_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input bit r);
    for (int i = n - 1; i >= 0; i--) drive(v[i], r);
  endtask

  task automatic restart();
    en = 1'b0; drive(1'b0, 1'b1);
    en = 1'b1;
  endtask

  int x0, p, rp;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0);
    check("reset_osc", osc_enable, 0);

    // Plain pattern: 0x4D expected, gap pairs let it transfer.
    en = 1'b1;
    x0 = n_xfer;
    send_bits(4'hA, 4, 1);
    send_bits(16'h65A6, 16, 1);
    send_bits(4'h3, 4, 1);
    check("t2_word", last_word, 8'h4D);
    check("t2_count", n_xfer - x0, 1);

    // Interleaved pattern with ready low, second word 0xB2, then extra bits dropped.
    x0 = n_xfer;
    send_bits(32'h4B478B4B, 32, 0);
    send_bits(16'h9A59, 16, 0);
    send_bits(6'h19, 6, 0);
    check("t3_held_valid", word_valid, 1);
    check("t3_held_word", word_out, 8'h4D);
    send_bits(8'h33, 8, 1);
    check("t3_count", n_xfer - x0, 2);
    check("t3_second", last_word, 8'hB2);

    // Repetition failure.
    send_bits(8'hFF, 8, 1);
    drive(0, 1);
    check("t4_rep", fail_rep, 1);
    check("t4_hf", health_fail, 1);
    check("t4_osc", osc_enable, 0);
    check("t4_valid", word_valid, 0);
    restart();
    check("t4_clear", {health_fail, fail_rep, fail_apt}, 0);

    // Adaptive proportion failure with short runs.
    send_bits(16'h1110, 16, 1);
    drive(1, 1);
    check("t5_apt", fail_apt, 1);
    check("t5_rep", fail_rep, 0);
    restart();

    // Partial word dropped by en going low.
    send_bits(4'hA, 4, 1);
    send_bits(12'h694, 12, 1);
    restart();
    x0 = n_xfer;
    send_bits(4'hA, 4, 1);
    send_bits(16'h65A6, 16, 1);
    send_bits(4'h3, 4, 1);
    check("t6_word", last_word, 8'h4D);
    check("t6_count", n_xfer - x0, 1);

    // Randomized traffic with varying bias and backpressure.
    x0 = n_xfer;
    for (int seg = 0; seg < 10; seg++) begin
      p  = (seg % 4 == 3) ? 85 : ((seg % 4 == 2) ? 65 : 50);
      rp = (seg % 3 == 0) ? 30 : 80;
      for (int c = 0; c < 300; c++) begin
        if (m_mode == M_FAIL || $urandom_range(0, 249) == 0) restart();
        else drive($urandom_range(0, 99) < p, $urandom_range(0, 99) < rp);
      end
    end
    check("rand_some_words", (n_xfer - x0) > 5, 1);

    // Async reset with a word pending.
    restart();
    send_bits(4'hA, 4, 0);
    send_bits(16'h65A6, 16, 0);
    send_bits(4'h3, 4, 0);
    check("t1_pre_valid", word_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t1_valid", word_valid, 0);
    check("t1_osc", osc_enable, 0);
    check("t1_word", word_out, 0);
    check("t1_flags", {health_fail, fail_rep, fail_apt}, 0);
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0);
    drive(0, 0);
    check("t1_idle_osc", osc_enable, 0);
    en = 1'b1;
    drive(1, 0);
    check("t1_restart_osc", osc_enable, 1);
    drive(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
